ps2_scancode_decoder: RTL and testbench

Consumes raw bytes from the PS/2 receiver and turns scan-code set 2 sequences (make, `F0` break, `E0` extended, `E0 F0` extended break) into single key events in the system clock domain. The block sits directly downstream of the PS/2 receiver. It takes the receiver's byte and its PS/2-clock-domain `flag` level, then drives key-event consumers (game/control logic) with a one-cycle `key_valid` strobe. It also flags malformed or stalled sequences.

---
 rtl/ps2_scancode_decoder.sv | 152 +++++++++++++++
 tb/tb_ps2_scancode_decoder.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_scancode_decoder.sv
// ps2_scancode_decoder
//
// Turns raw scan-code set 2 bytes from the PS/2 receiver into single key
// events in the system clock domain. Make, F0 break, E0 extended and E0 F0
// extended-break sequences collapse into one key_valid strobe carrying the
// stripped scan code plus extended/released flags. Malformed sequences and
// sequences that stall between bytes raise a one-cycle seq_error.
//
// Handshake: there is no backpressure. A byte is offered by a rising edge of
// the receiver's flag level (Key_code stable while flag is high); each event
// is presented for exactly one clock with key_valid high and the fields valid
// in that same cycle. Consumers must take it then. Fields hold between events.
//
// Ports
//   clock        system clock
//   reset        asynchronous, active-low reset
//   Key_code     byte from receiver, stable while flag is high
//   flag         receiver byte-ready level, asynchronous to clock
//   key_code     scan code of the last event, prefix bytes stripped
//   key_extended last event was E0-prefixed
//   key_released last event was a break (F0-prefixed)
//   key_valid    one-cycle event strobe
//   seq_error    one-cycle strobe on malformed sequence or timeout
//   state_dbg    current decoder state (IDLE=0, GOT_E0=1, GOT_F0=2, GOT_E0F0=3)
module ps2_scancode_decoder #(
   parameter int unsigned TIMEOUT_CYCLES = 2_500_000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [7:0] Key_code,
   input  logic       flag,
   output logic [7:0] key_code,
   output logic       key_extended,
   output logic       key_released,
   output logic       key_valid,
   output logic       seq_error,
   output logic [1:0] state_dbg
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      GOT_E0   = 2'd1,
      GOT_F0   = 2'd2,
      GOT_E0F0 = 2'd3
   } state_t;

   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   // Bytes that never form a key event (BAT result, echo, ack, resend, ...).
   function automatic logic is_non_event(input logic [7:0] b);
      case (b)
         8'h00, 8'hAA, 8'hEE, 8'hE1, 8'hFA,
         8'hFC, 8'hFD, 8'hFE, 8'hFF: return 1'b1;
         default:                    return 1'b0;
      endcase
   endfunction

   // flag synchronizer plus delayed copy for rising-edge detection
   logic s1_q, s2_q, s2_d_q;
   logic byte_stb;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [7:0]       code_q, code_d;
   logic             ext_q, ext_d;
   logic             rel_q, rel_d;
   logic             valid_q, valid_d;
   logic             err_q, err_d;

   assign byte_stb = s2_q & ~s2_d_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      code_d  = code_q;
      ext_d   = ext_q;
      rel_d   = rel_q;
      valid_d = 1'b0;
      err_d   = 1'b0;

      if (byte_stb) begin
         // A byte always wins over a coincident timeout.
         cnt_d = '0;
         if (Key_code == 8'hE0) begin
            // E0 restarts an extended sequence from any state.
            err_d   = (state_q != IDLE);
            state_d = GOT_E0;
         end else if (Key_code == 8'hF0) begin
            case (state_q)
               IDLE:    state_d = GOT_F0;
               GOT_E0:  state_d = GOT_E0F0;
               default: begin
                  err_d   = 1'b1;
                  state_d = GOT_F0;
               end
            endcase
         end else if (is_non_event(Key_code)) begin
            err_d   = (state_q != IDLE);
            state_d = IDLE;
         end else begin
            valid_d = 1'b1;
            code_d  = Key_code;
            ext_d   = (state_q == GOT_E0) || (state_q == GOT_E0F0);
            rel_d   = (state_q == GOT_F0) || (state_q == GOT_E0F0);
            state_d = IDLE;
         end
      end else if (state_q == IDLE) begin
         cnt_d = '0;
      end else if (cnt_q >= CNT_LAST) begin
         err_d   = 1'b1;
         state_d = IDLE;
         cnt_d   = '0;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         s1_q    <= 1'b0;
         s2_q    <= 1'b0;
         s2_d_q  <= 1'b0;
         state_q <= IDLE;
         cnt_q   <= '0;
         code_q  <= 8'h00;
         ext_q   <= 1'b0;
         rel_q   <= 1'b0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         s1_q    <= flag;
         s2_q    <= s1_q;
         s2_d_q  <= s2_q;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         code_q  <= code_d;
         ext_q   <= ext_d;
         rel_q   <= rel_d;
         valid_q <= valid_d;
         err_q   <= err_d;
      end
   end

   assign key_code     = code_q;
   assign key_extended = ext_q;
   assign key_released = rel_q;
   assign key_valid    = valid_q;
   assign seq_error    = err_q;
   assign state_dbg    = state_q;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Self-checking bench for ps2_scancode_decoder.
// The reference model tracks pending prefix bytes in a queue and applies the
// sequence rules per byte; expected outputs (with the cycle they must appear
// in) go into exp_q, and an independent monitor pops and compares whenever
// the DUT presents key_valid or seq_error.
module tb_ps2_scancode_decoder;

   localparam int TO = 100;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] Key_code = 8'h00;
   logic       flag = 1'b0;
   logic [7:0] key_code;
   logic       key_extended;
   logic       key_released;
   logic       key_valid;
   logic       seq_error;
   logic [1:0] state_dbg;

   ps2_scancode_decoder #(.TIMEOUT_CYCLES(TO)) dut (
      .clock        (clock),
      .reset        (reset),
      .Key_code     (Key_code),
      .flag         (flag),
      .key_code     (key_code),
      .key_extended (key_extended),
      .key_released (key_released),
      .key_valid    (key_valid),
      .seq_error    (seq_error),
      .state_dbg    (state_dbg)
   );

   // ---------------- clock ----------------
   always #5 clock = ~clock;

   // ---------------- bookkeeping ----------------
   int n_cmp  = 0;
   int n_fail = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      int         edge_n;
      logic [7:0] b;
   } sched_t;

   int         cyc = 0;
   int         last_proc = 0;
   logic [7:0] pend[$];          // prefix bytes seen in the open sequence
   sched_t     sched_q[$];       // bytes offered, with the clock edge they take effect
   sched_t     cur_s;
   logic [42:0] exp_q[$];        // {cycle[31:0], is_event, ext, rel, code[7:0]}
   logic [7:0] held_code = 8'h00;
   logic       held_ext = 1'b0;
   logic       held_rel = 1'b0;
   logic [7:0] non_ev[9] = '{8'h00, 8'hAA, 8'hEE, 8'hE1, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF};

   function automatic bit in_non_ev(input logic [7:0] b);
      foreach (non_ev[i]) if (non_ev[i] == b) return 1'b1;
      return 1'b0;
   endfunction

   function automatic bit pend_has(input logic [7:0] b);
      foreach (pend[i]) if (pend[i] == b) return 1'b1;
      return 1'b0;
   endfunction

   function automatic void push_err(input int c);
      exp_q.push_back({c[31:0], 1'b0, 1'b0, 1'b0, 8'h00});
   endfunction

   function automatic void model_byte(input logic [7:0] b, input int c);
      bit err;
      bit e;
      bit r;
      err = 1'b0;
      if (b == 8'hE0) begin
         err = (pend.size() != 0);
         pend.delete();
         pend.push_back(8'hE0);
      end else if (b == 8'hF0) begin
         if (pend.size() == 1 && pend[0] == 8'hE0) begin
            pend.push_back(8'hF0);
         end else begin
            err = (pend.size() != 0);
            pend.delete();
            pend.push_back(8'hF0);
         end
      end else if (in_non_ev(b)) begin
         err = (pend.size() != 0);
         pend.delete();
      end else begin
         e = pend_has(8'hE0);
         r = pend_has(8'hF0);
         exp_q.push_back({c[31:0], 1'b1, e, r, b});
         held_code = b;
         held_ext  = e;
         held_rel  = r;
         pend.delete();
      end
      if (err) push_err(c);
   endfunction

   always @(posedge clock) begin
      cyc = cyc + 1;
      if (reset) begin
         if (sched_q.size() > 0 && sched_q[0].edge_n == cyc) begin
            cur_s = sched_q.pop_front();
            model_byte(cur_s.b, cyc);
            last_proc = cyc;
         end else if (pend.size() > 0 && (cyc - last_proc) == TO) begin
            push_err(cyc);
            pend.delete();
         end
      end
   end

   // ---------------- monitor / scoreboard ----------------
   logic [42:0] e_q;
   always @(negedge clock) begin
      check("valid_err_exclusive", {63'd0, key_valid & seq_error}, 64'd0);
      if (key_valid || seq_error) begin
         if (exp_q.size() == 0) begin
            check("unexpected_output", {62'd0, key_valid, seq_error}, 64'd0);
         end else begin
            e_q = exp_q.pop_front();
            check("out_cycle", 64'(cyc), 64'(e_q[42:11]));
            check("out_kind", {62'd0, key_valid, seq_error}, e_q[10] ? 64'd2 : 64'd1);
            if (e_q[10]) begin
               check("ev_code", {56'd0, key_code}, {56'd0, e_q[7:0]});
               check("ev_ext", {63'd0, key_extended}, {63'd0, e_q[9]});
               check("ev_rel", {63'd0, key_released}, {63'd0, e_q[8]});
            end
         end
      end
      check("held_code", {56'd0, key_code}, {56'd0, held_code});
      check("held_ext", {63'd0, key_extended}, {63'd0, held_ext});
      check("held_rel", {63'd0, key_released}, {63'd0, held_rel});
   end

   // ---------------- driver ----------------
   // Raise flag at a falling edge; the first sampling edge is cyc+1 and the
   // decoder acts on the byte two edges later.
   task automatic send(input logic [7:0] b, input int hold, input int low);
      @(negedge clock);
      Key_code = b;
      flag     = 1'b1;
      sched_q.push_back('{cyc + 3, b});
      repeat (hold) @(negedge clock);
      flag = 1'b0;
      repeat (low) @(negedge clock);
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_code"}, {56'd0, key_code}, 64'd0);
      check({tag, "_ext"}, {63'd0, key_extended}, 64'd0);
      check({tag, "_rel"}, {63'd0, key_released}, 64'd0);
      check({tag, "_valid"}, {63'd0, key_valid}, 64'd0);
      check({tag, "_err"}, {63'd0, seq_error}, 64'd0);
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #5_000_000;
      n_cmp++;
      n_fail++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   // ---------------- main sequence ----------------
   initial begin
      int hold;
      int low;
      int cat;
      logic [7:0] b;

      #1 reset = 1'b0;
      idle(2);
      check_outputs_zero("reset_init");
      check("reset_state", {62'd0, state_dbg}, 64'd0);
      @(negedge clock);
      reset = 1'b1;
      idle(3);

      // plain make, F0 break, E0 F0 extended break with long flag hold
      send(8'h1C, 2, 4);
      send(8'hF0, 2, 4);
      send(8'h1C, 2, 4);
      send(8'hE0, 2, 4);
      send(8'hF0, 2, 4);
      send(8'h75, 1000, 4);

      // timeout after lone E0, then a normal make
      send(8'hE0, 1, 2);
      idle(150);
      check("idle_after_timeout", {62'd0, state_dbg}, 64'd0);
      send(8'h1C, 1, 5);

      // timeout boundary: byte on the timeout edge wins, one cycle later loses
      send(8'hE0, 1, 98);     // next byte processed exactly TO edges later
      send(8'h6B, 1, 5);
      send(8'hE0, 1, 99);     // next byte processed TO+1 edges later
      send(8'h6B, 1, 5);

      // malformed and non-event bytes
      send(8'hF0, 1, 3);
      send(8'hF0, 1, 3);
      send(8'h1C, 1, 3);
      send(8'hAA, 1, 3);
      send(8'hE0, 1, 3);
      send(8'hFA, 1, 3);
      send(8'hE0, 1, 3);
      send(8'hE0, 1, 3);
      send(8'h74, 1, 3);
      idle(10);

      // reset in the middle of E0 F0
      send(8'hE0, 1, 3);
      send(8'hF0, 1, 3);
      idle(5);
      #2 reset = 1'b0;
      pend.delete();
      sched_q.delete();
      held_code = 8'h00;
      held_ext  = 1'b0;
      held_rel  = 1'b0;
      #1 check_outputs_zero("reset_async");
      idle(2);
      check_outputs_zero("reset_hold");
      check("reset_hold_state", {62'd0, state_dbg}, 64'd0);
      reset = 1'b1;
      idle(2);
      send(8'h74, 1, 5);

      // randomized traffic
      for (int i = 0; i < 300; i++) begin
         cat = $urandom_range(0, 9);
         case (cat)
            0, 1:    b = 8'hE0;
            2, 3:    b = 8'hF0;
            4:       b = non_ev[$urandom_range(0, 8)];
            default: b = 8'($urandom_range(0, 255));
         endcase
         hold = $urandom_range(1, 4);
         if ($urandom_range(0, 9) == 0) low = 96 + $urandom_range(0, 8) - hold;
         else low = $urandom_range(1, 6);
         send(b, hold, low);
      end

      idle(150);
      check("exp_q_drained", 64'(exp_q.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
